// File: rtl/writeback_arbiter.sv
// Writeback stage: merges ALU results and one outstanding load into the single
// register-file write port, with a small ALU overflow buffer and RAW hazard detection.
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_byte_off,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    output logic        ld_busy,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard_stall,
    output logic        RegWrite,
    output logic [4:0]  rd,
    output logic [31:0] rd_write_data
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } alu_entry_t;

    alu_entry_t              fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_valid;
    logic [FIFO_DEPTH-1:0]   fifo_young;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;

    logic [REG_W-1:0]        pend_rd;
    logic [2:0]              pend_funct3;
    logic [1:0]              pend_off;

    logic                    resp_acc;
    logic                    issue_acc;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    head_elig;
    logic                    bypass_ok;
    logic                    sel_valid;
    logic [REG_W-1:0]        sel_rd;
    logic [DATA_W-1:0]       sel_data;
    logic                    deq;
    logic                    bypass;
    logic                    enq;
    logic                    young_in;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;
    logic [DATA_W-1:0]       load_data;
    alu_entry_t              head;

    // A response while busy retires the load; a new issue is taken if the slot is (being) freed.
    assign resp_acc   = ld_resp_valid && ld_busy;
    assign issue_acc  = ld_issue && (!ld_busy || resp_acc);
    assign fifo_empty = ~|fifo_valid;
    assign fifo_full  = &fifo_valid;
    assign alu_ready  = ~fifo_full;
    assign head       = fifo_mem[rd_ptr];

    // Entries younger than a still-pending load to the same rd must wait for it.
    assign head_elig  = fifo_valid[rd_ptr]
                        && !(fifo_young[rd_ptr] && ld_busy && (head.rd == pend_rd));
    assign bypass_ok  = fifo_empty && alu_valid && !(ld_busy && (alu_rd == pend_rd));
    assign young_in   = ld_busy && !resp_acc;
    assign enq        = alu_valid && alu_ready && !bypass;

    // Load data extraction and extension.
    always_comb begin
        lane_byte = ld_resp_data[7:0];
        case (pend_off)
            2'd1:    lane_byte = ld_resp_data[15:8];
            2'd2:    lane_byte = ld_resp_data[23:16];
            2'd3:    lane_byte = ld_resp_data[31:24];
            default: lane_byte = ld_resp_data[7:0];
        endcase
        lane_half = pend_off[1] ? ld_resp_data[31:16] : ld_resp_data[15:0];
        case (pend_funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'd0, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = ld_resp_data;
        endcase
    end

    // Write-port selection: load response, then buffered ALU, then bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        deq       = 1'b0;
        bypass    = 1'b0;
        if (resp_acc) begin
            sel_valid = 1'b1;
            sel_rd    = pend_rd;
            sel_data  = load_data;
        end else if (head_elig) begin
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
            deq       = 1'b1;
        end else if (bypass_ok) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            bypass    = 1'b1;
        end
    end

    // Decode must wait for any register whose value is not yet in the register file.
    always_comb begin
        hazard_stall = 1'b0;
        if (ld_busy && (((rs1 != '0) && (rs1 == pend_rd)) || ((rs2 != '0) && (rs2 == pend_rd)))) begin
            hazard_stall = 1'b1;
        end
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (((rs1 != '0) && (rs1 == fifo_mem[i].rd))
                                  || ((rs2 != '0) && (rs2 == fifo_mem[i].rd)))) begin
                hazard_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_busy     <= 1'b0;
            pend_rd     <= '0;
            pend_funct3 <= '0;
            pend_off    <= '0;
        end else if (issue_acc) begin
            ld_busy     <= 1'b1;
            pend_rd     <= ld_rd;
            pend_funct3 <= ld_funct3;
            pend_off    <= ld_byte_off;
        end else if (resp_acc) begin
            ld_busy     <= 1'b0;
        end
    end

    // Retiring a load ages out every young flag so a later load cannot capture old entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_valid <= '0;
            fifo_young <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (resp_acc) begin
                fifo_young <= '0;
            end
            if (deq) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                fifo_valid[wr_ptr] <= 1'b1;
                fifo_young[wr_ptr] <= young_in;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= '{rd: alu_rd, data: alu_data};
        end
    end

    // Results to x0 are consumed without a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            rd            <= '0;
            rd_write_data <= '0;
        end else begin
            RegWrite <= sel_valid && (sel_rd != '0);
            if (sel_valid) begin
                rd            <= sel_rd;
                rd_write_data <= sel_data;
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage for the RV100 core: the write-side driver of the integer register file. It merges single-cycle ALU results and one outstanding memory load into the register file's single write port (`RegWrite`, `rd`, `rd_write_data`), sign/zero-extends load data, buffers ALU results that lose arbitration, and raises a stall for decode on read-after-write hazards not covered by the register file's same-cycle write-to-read forwarding.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: ALU result buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  result accepted this cycle; equals FIFO not full.
- `ld_issue`  in  1  load sent to memory; legal only while `ld_busy`=0.
- `ld_rd`  in  5  load destination register.
- `ld_funct3`  in  3  load type, RISC-V encoding.
- `ld_byte_off`  in  2  address bits [1:0].
- `ld_resp_valid`  in  1  memory read data valid; cannot be back-pressured.
- `ld_resp_data`  in  32  aligned memory word.
- `ld_busy`  out  1  a load is outstanding.
- `rs1`, `rs2`  in  5 each  decode source registers.
- `hazard_stall`  out  1  decode must hold.
- `RegWrite`  out  1  register file write enable.
- `rd`  out  5  register file write address.
- `rd_write_data`  out  32  register file write data.

## Operation
- Load tracking: `ld_issue` sets `ld_busy` and latches rd/funct3/byte_off. `ld_resp_valid` with `ld_busy`=1 clears `ld_busy`. `ld_resp_valid` with `ld_busy`=0 is ignored. `ld_issue` while busy is a protocol error: ignored, latched fields unchanged.
- Load formatting: lane = `ld_byte_off`.
  - 000 LB: sign-extend byte[lane].
  - 100 LBU: zero-extend byte[lane].
  - 001 LH / 101 LHU: halfword `ld_byte_off[1]`, sign-/zero-extended.
  - 010 and all other codes: full word.
- ALU buffer:
  - FIFO of {rd, data, young}, accepting on `alu_valid && alu_ready`.
  - `young`=1 if the entry is enqueued while `ld_busy`=1. An enqueue in the same cycle as `ld_issue` gets `young`=0.
- Output selection each cycle, in priority order:
  1. Accepted load response.
  2. FIFO head, if eligible.
  3. Incoming ALU result, if FIFO empty and eligible (bypass; not enqueued).
  4. Nothing.
- Eligibility: an ALU result is ineligible when `young`=1, `ld_busy`=1 and its rd equals the pending load rd (WAW order). A bypass candidate is evaluated as `young` = `ld_busy`.
- Selected result is registered into `rd`/`rd_write_data`. `RegWrite`=1 only if selected and rd≠0. Results with rd=0 are consumed and discarded.
- `hazard_stall` (combinational from state and `rs1`/`rs2`) is high when a nonzero rs equals:
  - the pending load rd while `ld_busy`=1, or
  - the rd of any valid FIFO entry.
  
  The registered output stage is not a hazard, because the register file forwards it.

## Timing
- Reset values: `RegWrite`=0, `rd`=0, `rd_write_data`=0, `ld_busy`=0, FIFO empty, `alu_ready`=1, `hazard_stall`=0.
- Latency:
  - Load response at cycle N → `RegWrite` at N+1.
  - Unblocked ALU result at N with FIFO empty and no load response → N+1.
- Collision at N: the load response writes at N+1. The ALU result enqueues at N and writes no earlier than N+2.
- FIFO full: `alu_ready`=0. A same-cycle dequeue does not free a slot that cycle.
- Simultaneous dequeue and enqueue at non-full FIFO: both occur, occupancy unchanged.
- `ld_resp_valid` and `ld_issue` in the same cycle: response retires the old load, new load latched, `ld_busy` stays 1.
- Reset mid-operation: pending load and FIFO discarded. A late `ld_resp_valid` after reset is ignored.
- Output register holds one cycle only: with nothing selected, `RegWrite` returns to 0; `rd`/`rd_write_data` may hold stale values.

## Test plan
- ALU only: `alu_valid`, rd=5, data 0x1234 → next cycle `RegWrite`=1, rd=5, data 0x1234. rd=0 → `RegWrite`=0.
- Load formats, `ld_resp_data`=0x80F1_7F82:
  - LB off0 → 0xFFFFFF82
  - LBU off0 → 0x00000082
  - LB off1 → 0x0000007F
  - LH off2 → 0xFFFF80F1
  - LHU off0 → 0x00007F82
  - LW → 0x80F17F82
- Collision: load response rd=3 and ALU rd=4 in the same cycle → rd=3 write at N+1, rd=4 at N+2, `alu_ready` stays 1.
- WAW: load to x7 pending, then ALU rd=7 data 0xA → ALU held in FIFO until the response; x7 load data written first, 0xA one cycle later.
- Hazard:
  - Load x9 pending with `rs1`=9 → `hazard_stall`=1; clears the cycle after the response.
  - `rs2`=0 never stalls.
  - Two buffered entries with rd=4 → `alu_ready`=0 and stall on rs=4.
- Reset mid-load: `ld_issue`, assert `rst_n`=0 one cycle, then `ld_resp_valid` → no write, `ld_busy`=0.
